div_iter_core: RTL and testbench

- Iterative restoring divider for the calculator's divide operation: one quotient bit per clock, BITS iterations per operation.
- Drives the per-iteration "first cycle" (load) and "update" (commit difference) strobes that feed the partial-remainder register stage.
- Owns the shift/subtract datapath, iteration counter, divide-by-zero detection and result registers.
- Result is handed to the display/result mux with a one-cycle done pulse.

---
 rtl/div_iter_core.sv | 183 ++++++++++++++++++
 tb/tb_div_iter_core.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div_iter_core.sv
// div_iter_core: iterative restoring divider producing one quotient bit per clock.
// Define DIV_SIGNED_EN for two's-complement operands; the default build is unsigned only.
module div_iter_core #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            first_cycle,
    output logic            update,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_zero
);

    localparam int CW = $clog2(BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS-1:0] shreg_q, shreg_d;
    logic [BITS-1:0] dvsr_q, dvsr_d;
    logic [BITS-1:0] prem_q, prem_d;
    logic [BITS-1:0] quot_q, quot_d;
    logic [BITS-1:0] rem_q, rem_d;
    logic            done_q, done_d;
    logic            dz_q, dz_d;
    logic            dz_pend_q, dz_pend_d;

    logic [BITS-1:0] p_shift;
    logic [BITS:0]   trial;
    logic            nonneg;
    logic [BITS-1:0] q_step;
    logic [BITS-1:0] r_step;
    logic [BITS-1:0] q_fin;
    logic [BITS-1:0] r_fin;
    logic [BITS-1:0] ld_dvd;
    logic [BITS-1:0] ld_dvs;

`ifdef DIV_SIGNED_EN
    logic negq_q, negq_d;
    logic negr_q, negr_d;

    function automatic logic [BITS-1:0] abs_val(input logic signed [BITS-1:0] v);
        logic signed [BITS-1:0] neg_v;
        neg_v = -v;
        return v[BITS-1] ? $unsigned(neg_v) : $unsigned(v);
    endfunction

    function automatic logic [BITS-1:0] cond_neg(input logic [BITS-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    // The core divides magnitudes; signs are restored on the final write.
    // The most-negative value maps to its own bit pattern, which is the correct unsigned magnitude.
    assign ld_dvd = abs_val(dividend);
    assign ld_dvs = abs_val(divisor);
    assign q_fin  = cond_neg(q_step, negq_q);
    assign r_fin  = cond_neg(r_step, negr_q);
`else
    assign ld_dvd = dividend;
    assign ld_dvs = divisor;
    assign q_fin  = q_step;
    assign r_fin  = r_step;
`endif

    // The partial remainder never has its MSB set before the shift, so nothing is lost here.
    assign p_shift = {prem_q[BITS-2:0], shreg_q[BITS-1]};
    assign trial   = {1'b0, p_shift} - {1'b0, dvsr_q};
    assign nonneg  = ~trial[BITS];
    assign q_step  = {shreg_q[BITS-2:0], nonneg};
    assign r_step  = nonneg ? trial[BITS-1:0] : p_shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            shreg_q   <= '0;
            dvsr_q    <= '0;
            prem_q    <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            dz_pend_q <= 1'b0;
`ifdef DIV_SIGNED_EN
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            dvsr_q    <= dvsr_d;
            prem_q    <= prem_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            dz_pend_q <= dz_pend_d;
`ifdef DIV_SIGNED_EN
            negq_q    <= negq_d;
            negr_q    <= negr_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        dvsr_d    = dvsr_q;
        prem_d    = prem_q;
        quot_d    = quot_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        dz_pend_d = dz_pend_q;
`ifdef DIV_SIGNED_EN
        negq_d    = negq_q;
        negr_d    = negr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = ld_dvd;
                    dvsr_d  = ld_dvs;
                    prem_d  = '0;
                    count_d = '0;
                    dz_d    = 1'b0;
`ifdef DIV_SIGNED_EN
                    negq_d  = dividend[BITS-1] ^ divisor[BITS-1];
                    negr_d  = dividend[BITS-1];
`endif
                    if (divisor == '0) begin
                        state_d   = DONE;
                        quot_d    = '1;
                        rem_d     = dividend;
                        dz_pend_d = 1'b1;
                    end else begin
                        state_d   = CALC;
                        dz_pend_d = 1'b0;
                    end
                end
            end
            CALC: begin
                prem_d  = r_step;
                shreg_d = q_step;
                count_d = count_q + CW'(1);
                if (count_q == CW'(BITS - 1)) begin
                    state_d = DONE;
                    quot_d  = q_fin;
                    rem_d   = r_fin;
                end
            end
            DONE: begin
                // done and div_zero are registered so they rise together one cycle later.
                state_d = IDLE;
                done_d  = 1'b1;
                dz_d    = dz_pend_q;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q == CALC);
    assign first_cycle = (state_q == CALC) && (count_q == '0);
    assign update      = (state_q == CALC) && nonneg;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_zero    = dz_q;

endmodule

// File: tb/tb_div_iter_core.sv
// Self-checking bench for div_iter_core (BITS=8): directed steps plus random operations
// compared against an arithmetic reference model.
module tb_div_iter_core;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       first_cycle;
    logic       update;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_zero;

    int tests;
    int fails;

    div_iter_core #(.BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .dividend(dividend),
        .divisor(divisor),
        .first_cycle(first_cycle),
        .update(update),
        .busy(busy),
        .done(done),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division; qmag is the magnitude quotient whose
    // set bits are the CALC cycles that commit a difference.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic dz, output int qmag);
        int sa, sb, qi, ri;
        if (b == 8'd0) begin
            q = 8'hFF; r = a; dz = 1'b1; qmag = 0;
        end else begin
`ifdef DIV_SIGNED_EN
            sa = $signed(a);
            sb = $signed(b);
            qi = sa / sb;
            ri = sa % sb;
            qmag = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
`else
            sa = int'(a);
            sb = int'(b);
            qi = sa / sb;
            ri = sa % sb;
            qmag = qi;
`endif
            q = qi[7:0]; r = ri[7:0]; dz = 1'b0;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit noise, input string tag);
        logic [7:0] eq, er;
        logic       edz;
        int         qm, n, bc, fc, uc;
        logic       fc0;
        model(a, b, eq, er, edz, qm);
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
        n = 0; bc = 0; fc = 0; uc = 0; fc0 = first_cycle;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bc++;
            if (first_cycle === 1'b1) fc++;
            if (update === 1'b1) uc++;
            start = 1'b0;
            if (noise && (n == 3 || n == 8)) begin
                start = 1'b1; dividend = 8'($urandom); divisor = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 32'(n), edz ? 32'd1 : 32'd9);
        check({tag, "_busy_cycles"}, 32'(bc), edz ? 32'd0 : 32'd8);
        check({tag, "_first_cycles"}, 32'(fc), edz ? 32'd0 : 32'd1);
        check({tag, "_first_at_start"}, 32'(fc0), edz ? 32'd0 : 32'd1);
        check({tag, "_update_cycles"}, 32'(uc), 32'($countones(qm)));
        check({tag, "_quotient"}, 32'(quotient), 32'(eq));
        check({tag, "_remainder"}, 32'(remainder), 32'(er));
        check({tag, "_div_zero"}, 32'(div_zero), 32'(edz));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_first"}, 32'(first_cycle), 32'd0);
        check({tag, "_update"}, 32'(update), 32'd0);
        check({tag, "_div_zero"}, 32'(div_zero), 32'd0);
        check({tag, "_quotient"}, 32'(quotient), 32'd0);
        check({tag, "_remainder"}, 32'(remainder), 32'd0);
    endtask

    initial begin
        logic       seen;
        logic [7:0] ra, rb;
        tests = 0; fails = 0;
        reset = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge clk);

        run_op(8'd100, 8'd7, 1'b0, "d100_7");
        check("d100_7_q_lit", 32'(quotient), 32'd14);
        check("d100_7_r_lit", 32'(remainder), 32'd2);
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("quotient_held", 32'(quotient), 32'd14);

        run_op(8'd255, 8'd1, 1'b0, "d255_1");
        run_op(8'd3, 8'd10, 1'b0, "d3_10");

        run_op(8'd5, 8'd0, 1'b0, "d5_0");
        check("d5_0_q_lit", 32'(quotient), 32'hFF);
        check("d5_0_r_lit", 32'(remainder), 32'd5);
        run_op(8'd9, 8'd3, 1'b0, "d9_3");
        check("d9_3_dz_cleared", 32'(div_zero), 32'd0);
        check("d9_3_q_lit", 32'(quotient), 32'd3);

        // Reset sampled at the 4th CALC edge aborts the operation.
        start = 1'b1; dividend = 8'd200; divisor = 8'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midop_reset");
        reset = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        check("no_done_after_reset", 32'(seen), 32'd0);
        run_op(8'd200, 8'd9, 1'b0, "d200_9");

        run_op(8'd50, 8'd6, 1'b1, "noise50_6");
        run_op(8'd0, 8'd37, 1'b1, "zero_dividend");

        run_op(8'h9C, 8'd7, 1'b0, "sgn_m100_7");
`ifdef DIV_SIGNED_EN
        check("sgn_m100_7_q_lit", 32'(quotient), 32'hF2);
        check("sgn_m100_7_r_lit", 32'(remainder), 32'hFE);
`endif
        run_op(8'd100, 8'hF9, 1'b0, "sgn_100_m7");
`ifdef DIV_SIGNED_EN
        check("sgn_100_m7_q_lit", 32'(quotient), 32'hF2);
        check("sgn_100_m7_r_lit", 32'(remainder), 32'd2);
`endif
        run_op(8'h80, 8'hFF, 1'b0, "sgn_m128_m1");
`ifdef DIV_SIGNED_EN
        check("sgn_m128_m1_q_lit", 32'(quotient), 32'h80);
        check("sgn_m128_m1_r_lit", 32'(remainder), 32'd0);
`endif

        for (int k = 0; k < 40; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run_op(ra, rb, 1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
